fib_seq_gen: RTL and testbench

FIB_SEQ_GEN -- requirements
Module: fib_seq_gen

---
 rtl/fib_seq_gen_if.sv | 32 +++
 rtl/fib_seq_gen.sv | 122 ++++++++++++
 tb/tb_fib_seq_gen.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fib_seq_gen_if.sv
// Request/stream bundle for the Fibonacci sequence generator: run setup,
// ready/valid term stream and run status.
interface fib_seq_gen_if #(
  parameter int WIDTH     = 8,
  parameter int MAX_TERMS = 16
);
  localparam int CW = $clog2(MAX_TERMS + 1);

  logic             start;
  logic [WIDTH-1:0] seed0;
  logic [WIDTH-1:0] seed1;
  logic [CW-1:0]    num_terms;
  logic             wrap_mode;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic [CW-1:0]    term_idx;
  logic             overflow;
  logic             busy;
  logic             done;

  modport master (
    output start, seed0, seed1, num_terms, wrap_mode, out_ready,
    input  out_valid, out_data, out_last, term_idx, overflow, busy, done
  );

  modport slave (
    input  start, seed0, seed1, num_terms, wrap_mode, out_ready,
    output out_valid, out_data, out_last, term_idx, overflow, busy, done
  );
endinterface

// File: rtl/fib_seq_gen.sv
// Fibonacci term generator: emits num_terms terms from two seeds over a
// ready/valid stream, either wrapping on overflow or stopping before it.
module fib_seq_gen #(
  parameter int WIDTH     = 8,
  parameter int MAX_TERMS = 16
) (
  input  logic          clk,
  input  logic          reset,
  fib_seq_gen_if.slave  bus
);
  localparam int CW = $clog2(MAX_TERMS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] nxt;
  logic             nxt_ovf;
  logic [CW-1:0]    n_q;
  logic [CW-1:0]    term_idx;
  logic             wrap_q;
  logic             out_valid;
  logic             overflow;
  logic             busy;
  logic             done;

  logic [WIDTH:0]   sum;
  logic [CW-1:0]    n_clamped;
  logic             at_final_idx;
  logic             last_term;
  logic             xfer;

  // The extra sum bit is the carry that tells us the next-next term is unrepresentable.
  assign sum          = {1'b0, cur} + {1'b0, nxt};
  assign n_clamped    = (bus.num_terms > CW'(MAX_TERMS)) ? CW'(MAX_TERMS) : bus.num_terms;
  assign at_final_idx = (term_idx == n_q - CW'(1));
  assign last_term    = at_final_idx | (~wrap_q & nxt_ovf);
  assign xfer         = out_valid & bus.out_ready;

  assign bus.out_valid = out_valid;
  assign bus.out_data  = cur;
  assign bus.out_last  = out_valid & last_term;
  assign bus.term_idx  = term_idx;
  assign bus.overflow  = overflow;
  assign bus.busy      = busy;
  assign bus.done      = done;

  // NOTE: state is assigned with <= so every register samples pre-edge values,
  // independent of statement order inside the block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cur       <= '0;
      nxt       <= '0;
      nxt_ovf   <= 1'b0;
      n_q       <= '0;
      term_idx  <= '0;
      wrap_q    <= 1'b0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            cur      <= bus.seed0;
            nxt      <= bus.seed1;
            nxt_ovf  <= 1'b0;
            n_q      <= n_clamped;
            wrap_q   <= bus.wrap_mode;
            term_idx <= '0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            if (n_clamped == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= RUN;
              out_valid <= 1'b1;
            end
          end
        end

        RUN: begin
          if (xfer) begin
            cur      <= nxt;
            nxt      <= sum[WIDTH-1:0];
            nxt_ovf  <= sum[WIDTH];
            term_idx <= term_idx + CW'(1);
            // A carry into a term the run still needs is a real overflow.
            if (nxt_ovf && !at_final_idx) begin
              overflow <= 1'b1;
            end
            if (last_term) begin
              state     <= DONE;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fib_seq_gen.sv
// Self-checking bench for fib_seq_gen: directed and random runs compared
// against a plain-arithmetic Fibonacci model.
module tb_fib_seq_gen;
  localparam int WIDTH     = 8;
  localparam int MAX_TERMS = 16;
  localparam int CW        = $clog2(MAX_TERMS + 1);
  localparam int NONE      = 1 << 30;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  fib_seq_gen_if #(.WIDTH(WIDTH), .MAX_TERMS(MAX_TERMS)) bus ();

  fib_seq_gen #(.WIDTH(WIDTH), .MAX_TERMS(MAX_TERMS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  int exp_terms[$];
  bit exp_ovf[$];
  int emit_n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected emitted terms and the overflow flag after each transfer.
  task automatic build_model(input int s0, input int s1, input int n_req, input bit wrap);
    int n;
    int first_j;
    int modulus;
    int t[$];
    n       = (n_req > MAX_TERMS) ? MAX_TERMS : n_req;
    first_j = NONE;
    modulus = 1 << WIDTH;
    t       = {};
    t.push_back(s0);
    t.push_back(s1);
    for (int j = 2; j < n; j++) begin
      int s;
      s = t[j-1] + t[j-2];
      if (s >= modulus && first_j == NONE) first_j = j;
      t.push_back(s % modulus);
    end
    emit_n    = wrap ? n : ((first_j < n) ? first_j : n);
    exp_terms = {};
    exp_ovf   = {};
    for (int k = 0; k < emit_n; k++) begin
      exp_terms.push_back(t[k]);
      exp_ovf.push_back(first_j <= k + 1);
    end
  endtask

  // ready_mode: 0 = always ready, 1 = random, 2 = pattern 1,0,0,...
  task automatic run_case(input string name, input int s0, input int s1,
                          input int n_req, input bit wrap, input int ready_mode);
    int  k;
    int  guard;
    int  phase;
    int  done_cycles;
    bit  rdy;
    bit  final_ovf;
    build_model(s0, s1, n_req, wrap);
    final_ovf = (emit_n > 0) ? exp_ovf[emit_n-1] : 1'b0;

    @(negedge clk);
    bus.start     = 1'b1;
    bus.seed0     = WIDTH'(s0);
    bus.seed1     = WIDTH'(s1);
    bus.num_terms = CW'(n_req);
    bus.wrap_mode = wrap;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.seed0     = WIDTH'($urandom);
    bus.seed1     = WIDTH'($urandom);
    bus.num_terms = CW'($urandom);
    bus.wrap_mode = ~wrap;
    check($sformatf("%s_busy", name), 32'(bus.busy), 1);
    check($sformatf("%s_ovf_clr", name), 32'(bus.overflow), 0);

    if (emit_n == 0) begin
      done_cycles = 0;
      for (int c = 0; c < 3; c++) begin
        check($sformatf("%s_novalid%0d", name, c), 32'(bus.out_valid), 0);
        done_cycles += int'(bus.done);
        @(negedge clk);
      end
      check($sformatf("%s_done_pulses", name), done_cycles, 1);
      check($sformatf("%s_idle_busy", name), 32'(bus.busy), 0);
      return;
    end

    k = 0;
    guard = 0;
    phase = 0;
    while (k < emit_n && guard < 400) begin
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom % 2);
        default: rdy = (phase % 3 == 0);
      endcase
      phase++;
      bus.out_ready = rdy;
      bus.start     = ($urandom % 4 == 0);
      check($sformatf("%s_valid%0d", name, k), 32'(bus.out_valid), 1);
      check($sformatf("%s_data%0d", name, k), 32'(bus.out_data), exp_terms[k]);
      check($sformatf("%s_idx%0d", name, k), 32'(bus.term_idx), k);
      check($sformatf("%s_last%0d", name, k), 32'(bus.out_last), (k == emit_n - 1) ? 1 : 0);
      @(negedge clk);
      guard++;
      if (rdy) begin
        check($sformatf("%s_ovf%0d", name, k), 32'(bus.overflow), 32'(exp_ovf[k]));
        k++;
      end
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    if (k < emit_n) begin
      check($sformatf("%s_timeout", name), k, emit_n);
      return;
    end

    check($sformatf("%s_done", name), 32'(bus.done), 1);
    check($sformatf("%s_valid_drop", name), 32'(bus.out_valid), 0);
    check($sformatf("%s_final_ovf", name), 32'(bus.overflow), 32'(final_ovf));
    // A start during the DONE cycle must be ignored.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check($sformatf("%s_done_clr", name), 32'(bus.done), 0);
    check($sformatf("%s_idle", name), 32'(bus.busy), 0);
    @(negedge clk);
    check($sformatf("%s_stay_idle", name), 32'(bus.busy), 0);
  endtask

  task automatic check_all_zero(input string name);
    check($sformatf("%s_valid", name), 32'(bus.out_valid), 0);
    check($sformatf("%s_data", name), 32'(bus.out_data), 0);
    check($sformatf("%s_last", name), 32'(bus.out_last), 0);
    check($sformatf("%s_idx", name), 32'(bus.term_idx), 0);
    check($sformatf("%s_ovf", name), 32'(bus.overflow), 0);
    check($sformatf("%s_busy", name), 32'(bus.busy), 0);
    check($sformatf("%s_done", name), 32'(bus.done), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    bus.start     = 1'b0;
    bus.seed0     = '0;
    bus.seed1     = '0;
    bus.num_terms = '0;
    bus.wrap_mode = 1'b0;
    bus.out_ready = 1'b0;

    #1;
    check_all_zero("reset");
    bus.start = 1'b1;
    bus.num_terms = CW'(4);
    @(negedge clk);
    @(negedge clk);
    check("reset_ignores_start", 32'(bus.busy), 0);
    bus.start = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    run_case("fib10_wrap", 0, 1, 10, 1'b1, 0);
    run_case("fib16_stop", 0, 1, 16, 1'b0, 0);
    run_case("fib16_wrap", 0, 1, 16, 1'b1, 0);
    run_case("backpressure", 3, 4, 5, 1'b0, 2);
    run_case("zero_terms", 7, 9, 0, 1'b1, 0);
    run_case("one_term", 9, 11, 1, 1'b0, 0);
    run_case("clamp", 0, 1, MAX_TERMS + 3, 1'b1, 1);
    run_case("early_stop", 200, 100, 6, 1'b0, 1);

    // Reset in the middle of a run.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.seed0     = WIDTH'(5);
    bus.seed1     = WIDTH'(7);
    bus.num_terms = CW'(16);
    bus.wrap_mode = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    g = 0;
    while (bus.term_idx != CW'(5) && g < 40) begin
      @(negedge clk);
      g++;
    end
    check("midrun_reach_idx5", 32'(bus.term_idx), 5);
    reset = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    bus.start = 1'b1;
    @(negedge clk);
    check("midrun_hold_idle", 32'(bus.busy), 0);
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    run_case("after_reset", 5, 7, 6, 1'b1, 0);

    for (int r = 0; r < 8; r++) begin
      run_case($sformatf("rand%0d", r), int'($urandom % 256), int'($urandom % 256),
               int'($urandom % (MAX_TERMS + 4)), 1'($urandom % 2), int'($urandom % 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
